// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_unit
//  Brief    : Instruction-fetch front end. Owns the PC, drives the word
//             address into a combinational instruction memory and registers
//             the returned word into the IF/ID pipeline register. Handles
//             hazard freeze, EXE branch redirect and IF/ID flush, and counts
//             instructions accepted into IF/ID.
//  Revision : 1.0  initial release
// ============================================================================
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  input  logic        flush,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  logic [31:0] pc_reg;
  logic [31:0] pc_plus;
  logic [31:0] branch_target;
  logic        id_squash;
  logic        id_load;

  // Sequential address wraps modulo 2^32 by the natural adder width.
  assign pc_plus       = pc_reg + PC_STEP;
  // Misaligned targets are silently truncated to a word boundary.
  assign branch_target = branch_addr & WORD_MASK;
  assign imem_addr     = pc_reg & WORD_MASK;

  // A branch squashes the wrong-path word exactly like an explicit flush.
  assign id_squash = branch_taken | flush;
  // IF/ID accepts a real instruction only when neither squashed nor frozen.
  assign id_load   = ~id_squash & ~freeze;

  // PC register: branch redirect beats freeze, otherwise step sequentially.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else if (branch_taken) begin
      pc_reg <= branch_target;
    end else if (!freeze) begin
      pc_reg <= pc_plus;
    end
  end

  // IF/ID register: squash inserts the canonical all-zero bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc    <= 32'd0;
      id_inst  <= 32'd0;
      id_valid <= 1'b0;
    end else if (id_squash) begin
      id_pc    <= 32'd0;
      id_inst  <= 32'd0;
      id_valid <= 1'b0;
    end else if (!freeze) begin
      id_pc    <= pc_plus;
      id_inst  <= imem_inst;
      id_valid <= 1'b1;
    end
  end

  // Retired-fetch counter: bumps only when a real instruction enters IF/ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= 32'd0;
    end else if (id_load) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule
`default_nettype wire
